// File: rtl/sc_spi_arb.sv
// sc_spi_arb: round-robin arbiter and word sequencer that shares one SPI
// engine between NREQ requesters, with a watchdog that releases a stalled engine.

module sc_spi_arb #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 65535,
    parameter int TOW     = 16
) (
    input  logic             SYSCLK,
    input  logic             SYSRST,
    input  logic [NREQ-1:0]  REQ,
    input  logic [NREQ-1:0]  REQ_LAST,
    input  logic [NREQ*28-1:0] REQ_CFG,
    output logic [NREQ-1:0]  GNT,
    output logic [NREQ-1:0]  ACK,
    output logic [NREQ-1:0]  ERR,
    output logic [2:0]       CSSEL,
    output logic             ARBBUSY,
    output logic [7:0]       CLKDR,
    output logic [3:0]       CSSETUP,
    output logic [3:0]       CSHOLD,
    output logic [8:0]       DWIDTH,
    output logic             CPOL,
    output logic             CPHA,
    output logic             BORDER,
    output logic             TXSTART,
    output logic             CSEXTEND,
    input  logic             SPIBUSY,
    input  logic             SPICOMPLETE
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WBUSY = 3'd2,
        WDONE = 3'd3,
        NEXT  = 3'd4
    } state_t;

    state_t         state;
    logic [2:0]     ptr;
    logic [TOW-1:0] wdog;

    logic [NREQ-1:0] req_m;
    logic [7:0]      req_p;
    logic [7:0]      last_p;
    logic [27:0]     cfg_arr [8];

    logic            found;
    logic [2:0]      win;
    logic [3:0]      idx;
    logic [NREQ-1:0] win_oh;

    logic [2:0]      ptr_nxt;
    logic            counting;
    logic            done;
    logic            wd_hit;
    logic            expire;
    logic            req_g;
    logic            last_g;

    // The granted requester is masked during its own ACK cycle.
    assign req_m  = REQ & ~ACK;
    assign req_p  = 8'(req_m);
    assign last_p = 8'(REQ_LAST);
    assign req_g  = req_p[CSSEL];
    assign last_g = last_p[CSSEL];

    for (genvar i = 0; i < 8; i++) begin : g_cfg
        if (i < NREQ) begin : g_used
            assign cfg_arr[i] = REQ_CFG[i*28 +: 28];
        end else begin : g_pad
            assign cfg_arr[i] = '0;
        end
    end

    always_comb begin : search
        found = 1'b0;
        win   = ptr;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(NREQ)) begin
                idx = idx - 4'(NREQ);
            end
            if (!found && req_p[idx[2:0]]) begin
                found = 1'b1;
                win   = idx[2:0];
            end
        end
    end

    always_comb begin : onehot
        win_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            win_oh[i] = (win == 3'(i));
        end
    end

    assign ptr_nxt = (CSSEL == 3'(NREQ - 1)) ? 3'd0 : CSSEL + 3'd1;

    assign counting = (state == WBUSY) || (state == WDONE) || (state == NEXT);

    // A completion seen while still waiting for SPIBUSY is a fast engine.
    assign done = SPICOMPLETE && ((state == WBUSY) || (state == WDONE));

    // Flag the cycle in which the count reaches TIMEOUT; ERR follows next.
    if (TIMEOUT != 0) begin : g_wd
        assign wd_hit = (wdog == TOW'(TIMEOUT - 1));
    end else begin : g_nowd
        assign wd_hit = 1'b0;
    end

    assign expire = counting && wd_hit && !done;

    always_ff @(posedge SYSCLK) begin
        if (SYSRST) begin
            state    <= IDLE;
            ptr      <= '0;
            wdog     <= '0;
            GNT      <= '0;
            ACK      <= '0;
            ERR      <= '0;
            CSSEL    <= '0;
            ARBBUSY  <= 1'b0;
            CLKDR    <= '0;
            CSSETUP  <= '0;
            CSHOLD   <= '0;
            DWIDTH   <= '0;
            CPOL     <= 1'b0;
            CPHA     <= 1'b0;
            BORDER   <= 1'b0;
            TXSTART  <= 1'b0;
            CSEXTEND <= 1'b0;
        end else begin
            TXSTART <= 1'b0;
            ACK     <= '0;
            ERR     <= '0;
            if (counting) begin
                wdog <= wdog + 1'b1;
            end

            if (done) begin
                ACK <= GNT;
                if (CSEXTEND) begin
                    state <= NEXT;
                end else begin
                    GNT      <= '0;
                    ARBBUSY  <= 1'b0;
                    CSEXTEND <= 1'b0;
                    ptr      <= ptr_nxt;
                    state    <= IDLE;
                end
            end else if (expire) begin
                ERR      <= GNT;
                GNT      <= '0;
                ARBBUSY  <= 1'b0;
                CSEXTEND <= 1'b0;
                ptr      <= ptr_nxt;
                state    <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (found) begin
                            GNT     <= win_oh;
                            ARBBUSY <= 1'b1;
                            CSSEL   <= win;
                            {CLKDR, CSSETUP, CSHOLD, DWIDTH,
                             CPOL, CPHA, BORDER} <= cfg_arr[win];
                            state   <= START;
                        end
                    end
                    START: begin
                        TXSTART  <= 1'b1;
                        CSEXTEND <= !last_g;
                        wdog     <= '0;
                        state    <= WBUSY;
                    end
                    WBUSY: begin
                        if (SPIBUSY) begin
                            state <= WDONE;
                        end
                    end
                    WDONE: begin
                        state <= WDONE;
                    end
                    NEXT: begin
                        if (req_g) begin
                            state <= START;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
